// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port general-purpose register file with busy scoreboard.
//
// Two write lanes (lane 1 has priority on an address collision), two
// combinational read ports with optional same-cycle write bypass, an optional
// hardwired zero register and one busy bit per register. A synchronous reset
// clears every register and every busy bit.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wen0, waddr0, wdata0         write lane 0
//   wen1, waddr1, wdata1         write lane 1 (wins when both lanes hit one address)
//   raddr1/rdata1, raddr2/rdata2 combinational read ports
//   bset_en, bset_addr           mark a register busy (producer issued)
//   busy1, busy2                 scoreboard state of raddr1 / raddr2
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  bset_en,
    input  logic [ADDR_WIDTH-1:0] bset_addr,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    // A write or busy-set aimed at the hardwired zero register is dropped.
    logic we0;
    logic we1;
    logic bset_ok;

    assign we0     = wen0 && ((waddr0 != '0) || (ZERO_REG == 0));
    assign we1     = wen1 && ((waddr1 != '0) || (ZERO_REG == 0));
    assign bset_ok = bset_en && ((bset_addr != '0) || (ZERO_REG == 0));

    // Lane 1 is written after lane 0 so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we0) begin
                mem_q[waddr0] <= wdata0;
            end
            if (we1) begin
                mem_q[waddr1] <= wdata1;
            end
        end
    end

    // Retiring writes clear busy bits; a same-cycle set is applied last so a
    // newly issued producer supersedes the one retiring.
    always_comb begin
        busy_d = busy_q;
        if (we0) begin
            busy_d[waddr0] = 1'b0;
        end
        if (we1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (bset_ok) begin
            busy_d[bset_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports share one implementation; index 0 is port 1, index 1 is port 2.
    logic [1:0][ADDR_WIDTH-1:0] raddr_p;
    logic [1:0][DATA_WIDTH-1:0] rdata_p;
    logic [1:0]                 busy_p;

    assign raddr_p[0] = raddr1;
    assign raddr_p[1] = raddr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic zero_sel;
        logic whit0;
        logic whit1;
        logic byp0;
        logic byp1;

        assign zero_sel = (ZERO_REG != 0) && (raddr_p[p] == '0);
        assign whit0    = we0 && (waddr0 == raddr_p[p]);
        assign whit1    = we1 && (waddr1 == raddr_p[p]);
        assign byp0     = (BYPASS != 0) && whit0;
        assign byp1     = (BYPASS != 0) && whit1;

        assign rdata_p[p] = zero_sel ? '0     :
                            byp1     ? wdata1 :
                            byp0     ? wdata0 :
                                       mem_q[raddr_p[p]];

        // A forwarded value is already the retiring result, so it is not busy.
        assign busy_p[p] = !zero_sel && busy_q[raddr_p[p]] && !(byp0 || byp1);
    end

    assign rdata1 = rdata_p[0];
    assign rdata2 = rdata_p[1];
    assign busy1  = busy_p[0];
    assign busy2  = busy_p[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: drives three reg_file_mp configurations with shared stimulus
// (default, no zero register, no bypass) and checks every output each cycle
// against an array-based model, plus directed literal expectations.
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        bset_en;
    logic [4:0]  bset_addr;

    logic [2:0][31:0] rd1;
    logic [2:0][31:0] rd2;
    logic [2:0]       bz1;
    logic [2:0]       bz2;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
        .bset_en(bset_en), .bset_addr(bset_addr), .busy1(bz1[0]), .busy2(bz2[0])
    );

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
        .bset_en(bset_en), .bset_addr(bset_addr), .busy1(bz1[1]), .busy2(bz2[1])
    );

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
        .bset_en(bset_en), .bset_addr(bset_addr), .busy1(bz1[2]), .busy2(bz2[2])
    );

    // ---------------- model ----------------
    logic [31:0] m_mem  [3][32];
    bit          m_busy [3][32];
    bit          m_valid = 1'b0;

    function automatic bit zr(int i);
        return i != 1;
    endfunction

    function automatic bit bp(int i);
        return i != 2;
    endfunction

    function automatic bit wv0(int i);
        return wen0 && (waddr0 != 5'd0 || !zr(i));
    endfunction

    function automatic bit wv1(int i);
        return wen1 && (waddr1 != 5'd0 || !zr(i));
    endfunction

    function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
        if (zr(i) && a == 5'd0) return 32'd0;
        if (bp(i) && wv1(i) && waddr1 == a) return wdata1;
        if (bp(i) && wv0(i) && waddr0 == a) return wdata0;
        return m_mem[i][a];
    endfunction

    function automatic logic [31:0] exp_bz(int i, logic [4:0] a);
        if (zr(i) && a == 5'd0) return 32'd0;
        if (bp(i) && ((wv0(i) && waddr0 == a) || (wv1(i) && waddr1 == a))) return 32'd0;
        return {31'd0, m_busy[i][a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare on the falling edge, then advance the model by the edge to come.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("u%0d rdata1", i), rd1[i], exp_rd(i, raddr1));
                    chk($sformatf("u%0d rdata2", i), rd2[i], exp_rd(i, raddr2));
                    chk($sformatf("u%0d busy1", i), {31'd0, bz1[i]}, exp_bz(i, raddr1));
                    chk($sformatf("u%0d busy2", i), {31'd0, bz2[i]}, exp_bz(i, raddr2));
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    for (int a = 0; a < 32; a++) begin
                        m_mem[i][a]  = 32'd0;
                        m_busy[i][a] = 1'b0;
                    end
                end else begin
                    if (wv0(i)) m_mem[i][waddr0] = wdata0;
                    if (wv1(i)) m_mem[i][waddr1] = wdata1;
                    if (wv0(i)) m_busy[i][waddr0] = 1'b0;
                    if (wv1(i)) m_busy[i][waddr1] = 1'b0;
                    if (bset_en && !(zr(i) && bset_addr == 5'd0)) m_busy[i][bset_addr] = 1'b1;
                end
            end
            if (rst) m_valid = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        rst     = 1'b0;
        wen0    = 1'b0;
        wen1    = 1'b0;
        bset_en = 1'b0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1; wen0 = 1'b0; wen1 = 1'b0; bset_en = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr1 = '0; raddr2 = '0; bset_addr = '0;
        adv();
        adv();
        idle();

        // Post-reset sweep.
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            settle();
            chk("sweep rdata1", rd1[0], 32'd0);
            chk("sweep rdata2", rd2[1], 32'd0);
            chk("sweep busy1", {31'd0, bz1[0]}, 32'd0);
            adv();
        end

        // Reset discards an earlier write.
        wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        adv();
        idle(); rst = 1'b1;
        adv();
        idle(); raddr1 = 5'd5;
        settle();
        chk("r5 after reset", rd1[0], 32'd0);
        adv();

        // Dual write to one address: lane 1 wins, bypassed and stored.
        wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        raddr1 = 5'd7;
        settle();
        chk("r7 bypass lane1", rd1[0], 32'h22222222);
        chk("r7 nobypass old", rd1[2], 32'd0);
        adv();
        idle();
        settle();
        chk("r7 stored", rd1[0], 32'h22222222);
        chk("r7 stored nobyp", rd1[2], 32'h22222222);
        adv();

        // Zero register.
        wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF;
        bset_en = 1'b1; bset_addr = 5'd0; raddr1 = 5'd0;
        settle();
        chk("r0 same cycle", rd1[0], 32'd0);
        chk("r0 busy same", {31'd0, bz1[0]}, 32'd0);
        adv();
        idle();
        settle();
        chk("r0 after", rd1[0], 32'd0);
        chk("r0 busy after", {31'd0, bz1[0]}, 32'd0);
        chk("r0 ordinary", rd1[1], 32'hFFFFFFFF);
        chk("r0 ordinary busy", {31'd0, bz1[1]}, 32'd1);
        adv();

        // Busy set, then retired by a bypassed write.
        bset_en = 1'b1; bset_addr = 5'd9; raddr1 = 5'd9;
        settle();
        chk("r9 busy same cycle", {31'd0, bz1[0]}, 32'd0);
        adv();
        idle();
        settle();
        chk("r9 busy", {31'd0, bz1[0]}, 32'd1);
        adv();
        wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5A5A5;
        settle();
        chk("r9 bypass data", rd1[0], 32'hA5A5A5A5);
        chk("r9 bypass busy", {31'd0, bz1[0]}, 32'd0);
        chk("r9 nobyp busy", {31'd0, bz1[2]}, 32'd1);
        chk("r9 nobyp data", rd1[2], 32'd0);
        adv();
        idle();
        settle();
        chk("r9 busy cleared", {31'd0, bz1[0]}, 32'd0);
        chk("r9 stored", rd1[0], 32'hA5A5A5A5);
        adv();

        // Set wins over a same-cycle clear.
        bset_en = 1'b1; bset_addr = 5'd3;
        wen1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h3;
        adv();
        idle(); raddr1 = 5'd3;
        settle();
        chk("r3 busy set wins", {31'd0, bz1[0]}, 32'd1);
        chk("r3 data", rd1[0], 32'h3);
        adv();

        // No-bypass instance shows old value during the write.
        wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44; raddr2 = 5'd4;
        settle();
        chk("r4 nobyp old", rd2[2], 32'd0);
        chk("r4 bypass", rd2[0], 32'h44);
        adv();
        idle();
        settle();
        chk("r4 nobyp new", rd2[2], 32'h44);
        adv();

        // Reset overrides a same-cycle write and busy-set.
        wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h55;
        adv();
        rst = 1'b1; wen0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h12;
        bset_en = 1'b1; bset_addr = 5'd12;
        adv();
        idle(); raddr1 = 5'd12;
        settle();
        chk("r12 after reset", rd1[0], 32'd0);
        chk("r12 busy after reset", {31'd0, bz1[0]}, 32'd0);
        adv();

        // Random traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            wen0      = 1'($urandom_range(0, 1));
            waddr0    = rnd_addr();
            wdata0    = $urandom;
            wen1      = 1'($urandom_range(0, 1));
            waddr1    = ($urandom_range(0, 3) == 0) ? waddr0 : rnd_addr();
            wdata1    = $urandom;
            bset_en   = 1'($urandom_range(0, 1));
            bset_addr = rnd_addr();
            raddr1    = rnd_addr();
            raddr2    = ($urandom_range(0, 3) == 0) ? raddr1 : rnd_addr();
            adv();
        end
        idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port general-purpose register file for the CPU datapath. Next generation of the single-write-port register file.
- Adds a second write port, full-array synchronous reset, optional same-cycle write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard.
- Sits between decode (read and busy-set) and writeback (two retire lanes).

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- ZERO_REG, 1. 1: register 0 reads 0, ignores writes and busy-sets. 0: register 0 is ordinary.
- BYPASS, 1. 1: same-cycle write data forwarded to read ports. 0: reads return array contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wen0  in  1  write enable, lane 0.
- waddr0  in  ADDR_WIDTH  write address, lane 0.
- wdata0  in  DATA_WIDTH  write data, lane 0.
- wen1  in  1  write enable, lane 1 (priority lane).
- waddr1  in  ADDR_WIDTH  write address, lane 1.
- wdata1  in  DATA_WIDTH  write data, lane 1.
- raddr1  in  ADDR_WIDTH  read address, port 1.
- raddr2  in  ADDR_WIDTH  read address, port 2.
- rdata1  out  DATA_WIDTH  read data, port 1.
- rdata2  out  DATA_WIDTH  read data, port 2.
- bset_en  in  1  mark register busy (producer issued).
- bset_addr  in  ADDR_WIDTH  register to mark busy.
- busy1  out  1  scoreboard state of raddr1.
- busy2  out  1  scoreboard state of raddr2.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus 2**ADDR_WIDTH busy bits.
- Reset: on a clk edge with rst=1, every register and every busy bit is cleared to 0. All writes and bset_en are ignored that cycle. From the next cycle, every rdata is 0 and every busy is 0. Reset mid-operation discards pending writes.
- Writes: on clk edge when rst=0.
  - Lane k writes if wenk=1, and waddrk!=0 or ZERO_REG=0.
  - Both lanes to the same address in the same cycle: lane 1 value is stored.
  - Write latency: value readable from array on the cycle after the edge.
- Reads: combinational, zero latency, per read port.
  - ZERO_REG=1 and raddr=0: 0.
  - Else if BYPASS=1 and wen1 hits raddr (valid write): wdata1.
  - Else if BYPASS=1 and wen0 hits raddr: wdata0.
  - Else: array[raddr].
  - Both read ports may address the same register; both return the same value.
- Scoreboard: updated on clk edge when rst=0.
  - Clear: busy[a] <= 0 for each valid write address a (lane 0 or 1).
  - Set: busy[bset_addr] <= 1 if bset_en=1 and not (ZERO_REG=1 and bset_addr=0).
  - Set and clear on the same address in the same cycle: set wins (new producer supersedes retiring one).
  - Set on an already-busy register: stays 1.
  - Clear of a non-busy register: no effect.
- Busy outputs: combinational.
  - busyN = busy[raddrN] AND NOT (BYPASS=1 AND a valid write hits raddrN this cycle).
  - ZERO_REG=1 and raddrN=0: busyN=0.
  - A same-cycle bset_en does not affect busy outputs until the next cycle.
- No X on any output after the first reset edge.

Test Plan:
- Reset, then sweep raddr1/raddr2 over 0..31 -> every rdata=0 and every busy=0. Write 0xDEADBEEF to r5, assert rst one cycle, read r5 -> 0x00000000.
- wen0=1, waddr0=7, wdata0=0x11111111 with wen1=1, waddr1=7, wdata1=0x22222222. Same cycle, raddr1=7 -> 0x22222222 (BYPASS=1). Next cycle, wens low -> r7=0x22222222.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and bset r0 -> rdata1=0 and busy1=0, same cycle and after. With ZERO_REG=0 instance: r0 reads 0xFFFFFFFF next cycle.
- bset r9 -> busy1(raddr1=9)=1 next cycle. Next, wen0 r9=0xA5A5A5A5 with raddr1=9 -> same cycle rdata1=0xA5A5A5A5, busy1=0. Following cycle busy1=0.
- Same cycle: bset r3 and wen1 r3=0x3 -> next cycle busy[3]=1 and r3=0x3. BYPASS=0 instance: write r4=0x44 with raddr2=4 -> rdata2 shows old value that cycle, 0x44 next.
- rst asserted in the same cycle as wen0 r12=0x12 and bset r12 -> next cycle r12=0 and busy[12]=0.
